bit_serial_adder: RTL

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder_if.sv | 24 ++
 rtl/bit_serial_adder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/bit_serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The master side issues operands and start; the slave side returns status and result.
interface bit_serial_adder_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface : bit_serial_adder_if

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell is reused WIDTH times, LSB first.
// The operands are captured on start, the result bits are shifted in at the MSB,
// and sum/cout are published together with a one-cycle done pulse.

// Single-bit full adder used by the serial datapath.
module adder1bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum,
   output logic c
);
   assign sum = a ^ b ^ ci;
   assign c   = (a & b) | (ci & (a ^ b));
endmodule : adder1bit

module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   bit_serial_adder_if.slave bus
);
   // One extra counter bit so the count reaching WIDTH never wraps.
   localparam int              CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
   logic [CW-1:0]    cnt_q;
   logic             add_sum_s;
   logic             add_c_s;

   adder1bit u_adder1bit (
      .a   (a_q[0]),
      .b   (b_q[0]),
      .ci  (carry_q),
      .sum (add_sum_s),
      .c   (add_c_s)
   );

   // Result register shifted right with the fresh sum bit entering at the MSB.
   always_comb begin
      res_d            = res_q >> 1'b1;
      res_d[WIDTH-1]   = add_sum_s;
   end

   // Control FSM plus datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= bus.cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               // start and operand inputs are deliberately not looked at here.
               a_q     <= a_q >> 1'b1;
               b_q     <= b_q >> 1'b1;
               res_q   <= res_d;
               carry_q <= add_c_s;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  sum_q   <= res_d;
                  cout_q  <= add_c_s;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end else begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule : bit_serial_adder
